// File: rtl/char_buffer_pkg.sv
// Shared constants, state encoding and helpers for the text-mode character store.
package char_buffer_pkg;

  localparam int GLYPH_W  = 16;
  localparam int GLYPH_SH = $clog2(GLYPH_W);
  localparam int ADDR_W   = 11;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_FF    = 7'h0C;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    LINE_CLR = 2'd2,
    FULL_CLR = 2'd3
  } state_t;

  // True for codes that are stored in the grid as-is.
  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/char_buffer_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old data.
module char_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/char_buffer.sv
// Character grid for the display: accepts ASCII from the calculator side,
// maintains a write cursor with CR/BS/FF handling, and serves a one-cycle
// registered character lookup for the glyph renderer.
module char_buffer
  import char_buffer_pkg::*;
#(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [6:0]  i_char,
  output logic        o_ready,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic [6:0]  o_character,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [5:0]  o_cur_col,
  output logic [4:0]  o_cur_row
);

  localparam int CELLS = COLS * ROWS;

  state_t              state_q, state_d;
  logic [5:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;

  logic                accept_s;
  logic [4:0]          next_row_s;
  logic [ADDR_W-1:0]   row_base_s;
  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [6:0]          wdata_s;

  logic [11:0]         rd_col_s, rd_row_s;
  logic                rd_in_range_s;
  logic [ADDR_W-1:0]   raddr_s;
  logic [6:0]          ram_rdata_s;
  logic                rd_valid_q, rd_valid_d;
  logic [11:0]         x_q, x_d, y_q, y_d;

  assign o_ready    = (state_q == IDLE);
  assign accept_s   = i_valid && o_ready;
  assign row_base_s = ADDR_W'(32'(row_q) * COLS);
  assign next_row_s = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  // Next-state, cursor, clear counter and write-port control.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_idx_d = clr_idx_q;
    we_s      = 1'b0;
    waddr_s   = row_base_s + ADDR_W'(col_q);
    wdata_s   = ASCII_SPACE;
    case (state_q)
      INIT_CLR, FULL_CLR: begin
        we_s    = 1'b1;
        waddr_s = clr_idx_q;
        if (clr_idx_q == ADDR_W'(CELLS - 1)) begin
          clr_idx_d = {ADDR_W{1'b0}};
          col_d     = 6'd0;
          row_d     = 5'd0;
          state_d   = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      LINE_CLR: begin
        // row_q already points at the row being blanked.
        we_s    = 1'b1;
        waddr_s = row_base_s + clr_idx_q;
        if (clr_idx_q == ADDR_W'(COLS - 1)) begin
          clr_idx_d = {ADDR_W{1'b0}};
          state_d   = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (accept_s) begin
          if (is_printable(i_char)) begin
            we_s    = 1'b1;
            wdata_s = i_char;
            if (col_q == 6'(COLS - 1)) begin
              col_d     = 6'd0;
              row_d     = next_row_s;
              clr_idx_d = {ADDR_W{1'b0}};
              state_d   = LINE_CLR;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else if (i_char == ASCII_CR) begin
            col_d     = 6'd0;
            row_d     = next_row_s;
            clr_idx_d = {ADDR_W{1'b0}};
            state_d   = LINE_CLR;
          end else if (i_char == ASCII_BS) begin
            // Backspace never crosses into the previous row.
            if (col_q != 6'd0) begin
              col_d   = col_q - 6'd1;
              we_s    = 1'b1;
              waddr_s = row_base_s + ADDR_W'(col_q - 6'd1);
            end else begin
              col_d = col_q;
            end
          end else if (i_char == ASCII_FF) begin
            clr_idx_d = {ADDR_W{1'b0}};
            state_d   = FULL_CLR;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        clr_idx_d = {ADDR_W{1'b0}};
        state_d   = INIT_CLR;
      end
    endcase
  end

  // Control-path state registers.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT_CLR;
      col_q     <= 6'd0;
      row_q     <= 5'd0;
      clr_idx_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Pixel-to-cell address; off-grid pixels are flagged and read a dummy cell.
  always_comb begin
    rd_col_s      = i_x >> GLYPH_SH;
    rd_row_s      = i_y >> GLYPH_SH;
    rd_in_range_s = (32'(rd_col_s) < COLS) && (32'(rd_row_s) < ROWS);
    if (rd_in_range_s) begin
      raddr_s = ADDR_W'(32'(rd_row_s) * COLS + 32'(rd_col_s));
    end else begin
      raddr_s = {ADDR_W{1'b0}};
    end
    rd_valid_d = rd_in_range_s;
    x_d        = i_x;
    y_d        = i_y;
  end

  // Coordinates and in-range flag delayed to line up with the RAM output.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      x_q        <= 12'd0;
      y_q        <= 12'd0;
    end else begin
      rd_valid_q <= rd_valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  char_ram #(
    .DEPTH (CELLS),
    .AW    (ADDR_W),
    .DW    (7)
  ) u_ram (
    .clk   (pix_clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rdata (ram_rdata_s)
  );

  assign o_character = rd_valid_q ? ram_rdata_s : 7'h00;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_cur_col   = col_q;
  assign o_cur_row   = row_q;

endmodule

// File: tb/tb_char_buffer.sv
// Self-checking bench for char_buffer: vector table, hand sequences for the
// multi-cycle cases, and randomized traffic against a grid-level model.
module tb_char_buffer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        pix_clk = 1'b0;
  logic        rst     = 1'b1;
  logic        i_valid = 1'b0;
  logic [6:0]  i_char  = 7'h00;
  logic        o_ready;
  logic [11:0] i_x = 12'd0;
  logic [11:0] i_y = 12'd0;
  logic [6:0]  o_character;
  logic [11:0] o_x, o_y;
  logic [5:0]  o_cur_col;
  logic [4:0]  o_cur_row;

  char_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_char      (i_char),
    .o_ready     (o_ready),
    .i_x         (i_x),
    .i_y         (i_y),
    .o_character (o_character),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_cur_col   (o_cur_col),
    .o_cur_row   (o_cur_row)
  );

  always #5 pix_clk = ~pix_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the grid, the cursor and the expected not-ready length.
  logic [6:0] mem_m [CELLS];
  int cur_c = 0;
  int cur_r = 0;
  int exp_busy = 0;

  typedef struct {
    logic [6:0] ch;
    int col;
    int row;
    int busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < CELLS; i++) mem_m[i] = 7'h20;
  endtask

  task automatic model_new_row();
    cur_r = (cur_r + 1) % ROWS;
    for (int c = 0; c < COLS; c++) mem_m[cur_r * COLS + c] = 7'h20;
    exp_busy = COLS;
  endtask

  task automatic model_apply(input logic [6:0] c);
    exp_busy = 0;
    if (c >= 7'h20 && c <= 7'h7E) begin
      mem_m[cur_r * COLS + cur_c] = c;
      cur_c++;
      if (cur_c == COLS) begin
        cur_c = 0;
        model_new_row();
      end
    end else if (c == 7'h0D) begin
      cur_c = 0;
      model_new_row();
    end else if (c == 7'h08) begin
      if (cur_c > 0) begin
        cur_c--;
        mem_m[cur_r * COLS + cur_c] = 7'h20;
      end
    end else if (c == 7'h0C) begin
      model_fill();
      cur_c = 0;
      cur_r = 0;
      exp_busy = CELLS;
    end
  endtask

  function automatic logic [6:0] exp_char(input int x, input int y);
    if ((x / 16) < COLS && (y / 16) < ROWS) return mem_m[(y / 16) * COLS + (x / 16)];
    return 7'h00;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!o_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  // One handshake transfer, then measure how long o_ready stays low.
  task automatic send(input logic [6:0] c, output int busy);
    int w;
    wait_ready(w);
    i_valid = 1'b1;
    i_char  = c;
    tick();
    i_valid = 1'b0;
    model_apply(c);
    wait_ready(busy);
  endtask

  task automatic send_chk(input logic [6:0] c);
    int b;
    send(c, b);
    chk("busy_len", b, exp_busy);
  endtask

  task automatic chk_cursor(input string name, input int c, input int r);
    chk({name, "_col"}, 32'(o_cur_col), c);
    chk({name, "_row"}, 32'(o_cur_row), r);
  endtask

  task automatic check_pix(input int x, input int y);
    i_x = 12'(x);
    i_y = 12'(y);
    tick();
    chk("pix_char", 32'(o_character), 32'(exp_char(x, y)));
    chk("pix_x", 32'(o_x), x);
    chk("pix_y", 32'(o_y), y);
  endtask

  task automatic scan_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check_pix(c * 16 + int'($urandom_range(0, 15)), r * 16 + int'($urandom_range(0, 15)));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, 32'(o_ready), 0);
    chk({name, "_char"}, 32'(o_character), 0);
    chk({name, "_x"}, 32'(o_x), 0);
    chk({name, "_y"}, 32'(o_y), 0);
    chk({name, "_col"}, 32'(o_cur_col), 0);
    chk({name, "_row"}, 32'(o_cur_row), 0);
  endtask

  initial begin
    vec_t tbl [11];
    int   b;
    logic [6:0] last_c;
    logic [6:0] c;
    int   sel;

    tbl[0]  = '{7'h31, 1, 0, 0};
    tbl[1]  = '{7'h2B, 2, 0, 0};
    tbl[2]  = '{7'h32, 3, 0, 0};
    tbl[3]  = '{7'h08, 2, 0, 0};
    tbl[4]  = '{7'h07, 2, 0, 0};
    tbl[5]  = '{7'h0D, 0, 1, 40};
    tbl[6]  = '{7'h41, 1, 1, 0};
    tbl[7]  = '{7'h08, 0, 1, 0};
    tbl[8]  = '{7'h08, 0, 1, 0};
    tbl[9]  = '{7'h7F, 0, 1, 0};
    tbl[10] = '{7'h7E, 1, 1, 0};

    // Reset and initial clear.
    i_x = 12'd100;
    i_y = 12'd50;
    #2;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    model_fill();
    cur_c = 0;
    cur_r = 0;
    wait_ready(b);
    chk("init_clr_len", b, CELLS);
    scan_all();
    check_pix(700, 10);
    check_pix(10, 480);
    check_pix(4095, 4095);

    // Vector table from cursor (0,0).
    foreach (tbl[i]) begin
      send(tbl[i].ch, b);
      chk("tbl_busy", b, tbl[i].busy);
      chk_cursor("tbl", tbl[i].col, tbl[i].row);
    end
    i_x = 12'd20;
    i_y = 12'd5;
    tick();
    chk("plus_char", 32'(o_character), 32'h2B);
    chk("plus_x", 32'(o_x), 20);
    chk("plus_y", 32'(o_y), 5);
    scan_all();

    // Read and write of the same cell on one edge returns the old code.
    i_x = 12'(1 * 16 + 3);
    i_y = 12'(1 * 16 + 7);
    i_valid = 1'b1;
    i_char  = 7'h52;
    tick();
    i_valid = 1'b0;
    chk("read_first_old", 32'(o_character), 32'h20);
    model_apply(7'h52);
    tick();
    chk("read_after_write", 32'(o_character), 32'h52);
    chk_cursor("rf", 2, 1);

    // Full clear, then a 40-character line that wraps.
    send_chk(7'h0C);
    chk_cursor("ff", 0, 0);
    last_c = 7'h20;
    for (int i = 0; i < COLS; i++) begin
      last_c = 7'($urandom_range(32, 126));
      send(last_c, b);
      chk("line_busy", b, (i == COLS - 1) ? COLS : 0);
    end
    chk_cursor("wrap", 0, 1);
    check_pix(39 * 16 + 4, 2);
    chk("col39_char", 32'(o_character), 32'(last_c));
    scan_all();

    // CR from the last row wraps to row 0 and clears it.
    for (int i = 0; i < 40 && cur_r != 28; i++) send_chk(7'h0D);
    send_chk(7'h5A);
    send_chk(7'h51);
    send_chk(7'h0D);
    chk_cursor("row29", 0, 29);
    send(7'h0D, b);
    chk("row_wrap_busy", b, 40);
    chk_cursor("row_wrap", 0, 0);
    check_pix(3, 28 * 16 + 3);
    chk("row28_kept", 32'(o_character), 32'h5A);
    scan_all();

    // i_valid held through LINE_CLR must not transfer the held character.
    i_valid = 1'b1;
    i_char  = 7'h0D;
    tick();
    model_apply(7'h0D);
    i_char = 7'h51;
    b = 0;
    while (!o_ready && b < 3000) begin
      tick();
      b++;
    end
    i_valid = 1'b0;
    chk("hold_busy", b, 40);
    tick();
    chk_cursor("hold", 0, 1);

    // Backspace after a write, and backspace at column 0.
    send_chk(7'h0D);
    send_chk(7'h0D);
    for (int i = 0; i < 5; i++) send_chk(7'h61 + 7'(i));
    send_chk(7'h41);
    send_chk(7'h08);
    chk_cursor("bs", 5, 3);
    check_pix(5 * 16 + 8, 3 * 16 + 8);
    chk("bs_cell", 32'(o_character), 32'h20);
    for (int i = 0; i < 5; i++) send_chk(7'h08);
    send_chk(7'h08);
    chk_cursor("bs_col0", 0, 3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 75) c = 7'($urandom_range(32, 126));
      else if (sel < 87) c = 7'h0D;
      else if (sel < 97) c = 7'h08;
      else if (sel < 98) c = 7'h0C;
      else begin
        c = 7'($urandom_range(0, 31));
        if (c == 7'h0D || c == 7'h08 || c == 7'h0C) c = 7'h7F;
      end
      send_chk(c);
      chk_cursor("rnd", cur_c, cur_r);
      check_pix(int'($urandom_range(0, 799)), int'($urandom_range(0, 599)));
    end
    scan_all();

    // Reset in the middle of a full clear.
    send_chk(7'h58);
    wait_ready(b);
    i_valid = 1'b1;
    i_char  = 7'h0C;
    tick();
    i_valid = 1'b0;
    i_x = 12'd300;
    i_y = 12'd200;
    repeat (600) tick();
    chk("mid_clr_ready", 32'(o_ready), 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    tick();
    rst = 1'b0;
    model_fill();
    cur_c = 0;
    cur_r = 0;
    wait_ready(b);
    chk("reinit_len", b, CELLS);
    chk_cursor("reinit", 0, 0);
    scan_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
